// File: rtl/fwrisc_fetch.sv
// fwrisc_fetch: instruction fetch unit with optional RVC half-word extraction.
// Ports:
//   clock, reset            - clock and asynchronous active-high reset
//   iaddr/ivalid/iready     - word-aligned instruction-memory request
//   idata                   - read data, valid in the cycle iready is high
//   fetch_valid/decode_ready- handshake toward decode
//   instr/instr_c/pc        - presented instruction, compressed flag, address
//   redirect/redirect_pc    - one-cycle request from exec to restart fetch
module fwrisc_fetch #(
    parameter int unsigned ENABLE_COMPRESSED = 1,
    parameter logic [31:0] RESET_VECTOR      = 32'h8000_0000
) (
    input  logic        clock,
    input  logic        reset,
    output logic [31:0] iaddr,
    output logic        ivalid,
    input  logic        iready,
    input  logic [31:0] idata,
    output logic        fetch_valid,
    input  logic        decode_ready,
    output logic [31:0] instr,
    output logic        instr_c,
    output logic [31:0] pc,
    input  logic        redirect,
    input  logic [31:0] redirect_pc
);

    localparam bit EC = (ENABLE_COMPRESSED != 0);

    typedef enum logic [1:0] {
        REQ_LO,
        REQ_HI,
        PRESENT
    } state_e;

    state_e      state_q, state_n;
    logic [31:0] pc_q, pc_n;
    logic [31:0] iaddr_q, iaddr_n;
    logic        ivalid_q, ivalid_n;
    logic        fv_q, fv_n;
    logic [31:0] instr_q, instr_n;
    logic        c_q, c_n;
    logic        buf_valid_q, buf_valid_n;
    logic [15:0] buf_half_q, buf_half_n;
    logic [31:0] buf_tag_q, buf_tag_n;
    logic [15:0] low_half_q, low_half_n;
    logic        discard_q, discard_n;

    logic [31:0] pc_al;
    logic [31:0] pc_inc;
    logic [31:0] pc_inc_al;
    logic [31:0] rd_pc;
    logic        lo_c;
    logic        hi_c;
    logic        pc_odd;

    // bit 0 of redirect_pc never matters: instructions are half-word aligned
    logic unused_ok;
    assign unused_ok = redirect_pc[0];

    assign pc_al     = {pc_q[31:2], 2'b00};
    assign pc_inc    = pc_q + (c_q ? 32'd2 : 32'd4);
    assign pc_inc_al = {pc_inc[31:2], 2'b00};
    assign rd_pc     = EC ? {redirect_pc[31:1], 1'b0}
                          : {redirect_pc[31:2], 2'b00};
    assign lo_c      = EC && (idata[1:0] != 2'b11);
    assign hi_c      = (idata[17:16] != 2'b11);
    assign pc_odd    = EC && pc_q[1];

    always_comb begin
        state_n     = state_q;
        pc_n        = pc_q;
        iaddr_n     = iaddr_q;
        ivalid_n    = ivalid_q;
        fv_n        = fv_q;
        instr_n     = instr_q;
        c_n         = c_q;
        buf_valid_n = buf_valid_q;
        buf_half_n  = buf_half_q;
        buf_tag_n   = buf_tag_q;
        low_half_n  = low_half_q;
        discard_n   = discard_q;

        if (redirect) begin
            pc_n        = rd_pc;
            buf_valid_n = 1'b0;
            fv_n        = 1'b0;
            state_n     = REQ_LO;
            if (ivalid_q && !iready) begin
                // request must stay stable; drop its data on return
                discard_n = 1'b1;
            end else begin
                ivalid_n  = 1'b1;
                iaddr_n   = {rd_pc[31:2], 2'b00};
                discard_n = 1'b0;
            end
        end else begin
            unique case (state_q)
                REQ_LO: begin
                    if (!ivalid_q) begin
                        ivalid_n = 1'b1;
                        iaddr_n  = pc_al;
                    end else if (iready) begin
                        if (discard_q) begin
                            discard_n = 1'b0;
                            iaddr_n   = pc_al;
                        end else if (!pc_odd) begin
                            ivalid_n = 1'b0;
                            fv_n     = 1'b1;
                            state_n  = PRESENT;
                            if (lo_c) begin
                                instr_n     = {16'h0000, idata[15:0]};
                                c_n         = 1'b1;
                                buf_valid_n = 1'b1;
                                buf_half_n  = idata[31:16];
                                buf_tag_n   = {pc_q[31:2], 2'b10};
                            end else begin
                                instr_n = idata;
                                c_n     = 1'b0;
                            end
                        end else if (hi_c) begin
                            ivalid_n = 1'b0;
                            fv_n     = 1'b1;
                            state_n  = PRESENT;
                            instr_n  = {16'h0000, idata[31:16]};
                            c_n      = 1'b1;
                        end else begin
                            // 32-bit instruction straddles the word boundary
                            low_half_n = idata[31:16];
                            state_n    = REQ_HI;
                            iaddr_n    = pc_al + 32'd4;
                        end
                    end
                end
                REQ_HI: begin
                    if (!ivalid_q) begin
                        ivalid_n = 1'b1;
                        iaddr_n  = pc_al + 32'd4;
                    end else if (iready) begin
                        ivalid_n    = 1'b0;
                        fv_n        = 1'b1;
                        state_n     = PRESENT;
                        instr_n     = {idata[15:0], low_half_q};
                        c_n         = 1'b0;
                        buf_valid_n = 1'b1;
                        buf_half_n  = idata[31:16];
                        buf_tag_n   = pc_al + 32'd6;
                    end
                end
                PRESENT: begin
                    if (fv_q && decode_ready) begin
                        pc_n        = pc_inc;
                        fv_n        = 1'b0;
                        buf_valid_n = 1'b0;
                        if (buf_valid_q && (buf_tag_q == pc_inc)) begin
                            if (buf_half_q[1:0] != 2'b11) begin
                                fv_n    = 1'b1;
                                instr_n = {16'h0000, buf_half_q};
                                c_n     = 1'b1;
                            end else begin
                                low_half_n = buf_half_q;
                                state_n    = REQ_HI;
                                ivalid_n   = 1'b1;
                                iaddr_n    = pc_inc_al + 32'd4;
                            end
                        end else begin
                            state_n  = REQ_LO;
                            ivalid_n = 1'b1;
                            iaddr_n  = pc_inc_al;
                        end
                    end
                end
                default: begin
                    state_n = REQ_LO;
                end
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= REQ_LO;
            pc_q        <= RESET_VECTOR;
            iaddr_q     <= {RESET_VECTOR[31:2], 2'b00};
            ivalid_q    <= 1'b0;
            fv_q        <= 1'b0;
            instr_q     <= 32'h0;
            c_q         <= 1'b0;
            buf_valid_q <= 1'b0;
            buf_half_q  <= 16'h0;
            buf_tag_q   <= 32'h0;
            low_half_q  <= 16'h0;
            discard_q   <= 1'b0;
        end else begin
            state_q     <= state_n;
            pc_q        <= pc_n;
            iaddr_q     <= iaddr_n;
            ivalid_q    <= ivalid_n;
            fv_q        <= fv_n;
            instr_q     <= instr_n;
            c_q         <= c_n;
            buf_valid_q <= buf_valid_n;
            buf_half_q  <= buf_half_n;
            buf_tag_q   <= buf_tag_n;
            low_half_q  <= low_half_n;
            discard_q   <= discard_n;
        end
    end

    assign iaddr       = iaddr_q;
    assign ivalid      = ivalid_q;
    assign fetch_valid = fv_q;
    assign instr       = instr_q;
    assign instr_c     = c_q;
    assign pc          = pc_q;

endmodule

// File: tb/tb_fwrisc_fetch.sv
// tb_fwrisc_fetch: directed bench for fwrisc_fetch.
// Expected instructions are queued when memory contents are set up.
module tb_fwrisc_fetch;

    localparam logic [31:0] RV = 32'h8000_0000;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] iaddr;
    logic        ivalid;
    logic        iready = 1'b0;
    logic [31:0] idata = 32'h0;
    logic        fetch_valid;
    logic        decode_ready = 1'b0;
    logic [31:0] instr;
    logic        instr_c;
    logic [31:0] pc;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'h0;

    logic [31:0] mem [0:127];

    typedef struct packed {
        logic [31:0] instr;
        logic        c;
        logic [31:0] pc;
    } exp_t;

    exp_t sb[$];
    int checks = 0;
    int failures = 0;

    fwrisc_fetch #(
        .ENABLE_COMPRESSED(1),
        .RESET_VECTOR(RV)
    ) dut (
        .clock(clock),
        .reset(reset),
        .iaddr(iaddr),
        .ivalid(ivalid),
        .iready(iready),
        .idata(idata),
        .fetch_valid(fetch_valid),
        .decode_ready(decode_ready),
        .instr(instr),
        .instr_c(instr_c),
        .pc(pc),
        .redirect(redirect),
        .redirect_pc(redirect_pc)
    );

    always #5 clock = ~clock;

    // memory read path settles shortly after each rising edge
    always @(posedge clock) begin
        #2 idata = mem[iaddr[8:2]];
    end

    task automatic chk(input string tag,
                       input logic [95:0] obs,
                       input logic [95:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [31:0] i, input logic c,
                        input logic [31:0] a);
        exp_t e;
        e.instr = i;
        e.c     = c;
        e.pc    = a;
        sb.push_back(e);
    endtask

    task automatic consume(input string tag, input bit accept);
        int n;
        exp_t e;
        n = 0;
        while (!fetch_valid && n < 20) begin
            @(negedge clock);
            n++;
        end
        if (!fetch_valid) begin
            chk({tag, "_timeout"}, {95'h0, fetch_valid}, 96'h1);
        end else begin
            e = (sb.size() > 0) ? sb.pop_front() : '0;
            chk(tag, {31'h0, instr, instr_c, pc},
                {31'h0, e.instr, e.c, e.pc});
            if (accept) begin
                decode_ready = 1'b1;
                @(negedge clock);
                decode_ready = 1'b0;
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 128; i++) mem[i] = 32'h0000_0013 + (i << 7);
        mem[0]   = 32'h0000_0013;
        mem[64]  = 32'h0010_0113;
        mem[127] = 32'h0040_0093;

        // reset state, first request, hold under back-pressure
        #1 reset = 1'b1;
        #1;
        chk("rst_state", {29'h0, fetch_valid, ivalid, instr, instr_c, pc},
            {29'h0, 1'b0, 1'b0, 32'h0, 1'b0, RV});
        iready = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        chk("first_req", {63'h0, ivalid, iaddr}, {63'h0, 1'b1, RV});
        push(32'h0000_0013, 1'b0, RV);
        @(negedge clock);
        iready = 1'b0;
        consume("first_instr", 1'b0);
        for (int k = 0; k < 5; k++) begin
            @(negedge clock);
            chk("hold", {29'h0, fetch_valid, ivalid, instr, instr_c, pc},
                {29'h0, 1'b1, 1'b0, 32'h0000_0013, 1'b0, RV});
        end
        decode_ready = 1'b1;
        @(negedge clock);
        decode_ready = 1'b0;
        chk("seq_addr", {62'h0, fetch_valid, ivalid, iaddr},
            {62'h0, 1'b0, 1'b1, RV + 32'd4});

        // redirect while request pending
        redirect    = 1'b1;
        redirect_pc = 32'h8000_0101;
        @(negedge clock);
        redirect = 1'b0;
        chk("redir_hold", {62'h0, fetch_valid, ivalid, iaddr},
            {62'h0, 1'b0, 1'b1, RV + 32'd4});
        iready = 1'b1;
        @(negedge clock);
        chk("redir_addr", {62'h0, fetch_valid, ivalid, iaddr},
            {62'h0, 1'b0, 1'b1, 32'h8000_0100});
        push(32'h0010_0113, 1'b0, 32'h8000_0100);
        consume("redir_instr", 1'b1);

        // pc wraps past the top of the address space
        iready      = 1'b0;
        redirect    = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        @(negedge clock);
        redirect = 1'b0;
        iready   = 1'b1;
        push(32'h0040_0093, 1'b0, 32'hFFFF_FFFC);
        consume("wrap_instr", 1'b1);
        chk("wrap_addr", {63'h0, ivalid, iaddr}, {63'h0, 1'b1, 32'h0});

        // two compressed halves from one word
        iready = 1'b0;
        reset  = 1'b1;
        @(negedge clock);
        mem[0] = 32'h4505_4501;
        mem[1] = 32'h0000_0013;
        iready = 1'b1;
        reset  = 1'b0;
        push(32'h0000_4501, 1'b1, RV);
        push(32'h0000_4505, 1'b1, RV + 32'd2);
        consume("c_lo", 1'b1);
        chk("c_b2b", {94'h0, fetch_valid, ivalid}, {94'h0, 1'b1, 1'b0});
        consume("c_hi", 1'b1);

        // 32-bit instruction spanning two words, then buffered half
        iready = 1'b0;
        reset  = 1'b1;
        @(negedge clock);
        mem[0] = 32'h0513_4501;
        mem[1] = 32'h1234_0000;
        iready = 1'b1;
        reset  = 1'b0;
        push(32'h0000_4501, 1'b1, RV);
        consume("s3_c", 1'b1);
        chk("s3_reqhi", {62'h0, fetch_valid, ivalid, iaddr},
            {62'h0, 1'b0, 1'b1, RV + 32'd4});
        push(32'h0000_0513, 1'b0, RV + 32'd2);
        consume("s3_span", 1'b1);
        push(32'h0000_1234, 1'b1, RV + 32'd6);
        consume("s3_buf", 1'b0);
        chk("s3_b2b", {95'h0, ivalid}, 96'h0);

        // asynchronous reset while presenting
        #2 reset = 1'b1;
        #1;
        chk("async_rst", {62'h0, fetch_valid, ivalid, pc},
            {62'h0, 1'b0, 1'b0, RV});
        @(negedge clock);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
